// File: rtl/timer_dev_if.sv
// CPU external-bus bundle for the timer: word address, write data/strobe, read data.
// Combinational read path, writes accepted every cycle; no backpressure.
interface timer_dev_if;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWrite;
  logic [31:0] PrRD;

  modport master (output PrAddr, output PrWD, output PrWrite, input PrRD);
  modport slave  (input PrAddr, input PrWD, input PrWrite, output PrRD);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) driving one IRQ; TIMER_MODE1_EN adds auto-reload.
// Reads 0-cycle combinational, writes land on the next edge; bus never stalls.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state, state_nxt;
  logic [31:0] preset, count, count_nxt;
  logic        ctrl_en, ctrl_im, irq_flag;
  logic [1:0]  ctrl_mode;
  logic        mode1;
  logic        hit, wr_ctrl, wr_preset;
  logic        irq_set, irq_clr, en_clr;

  assign hit       = (bus.PrAddr[29:2] == BASE_ADDR[31:4]);
  assign wr_ctrl   = bus.PrWrite && hit && (bus.PrAddr[1:0] == 2'd0);
  assign wr_preset = bus.PrWrite && hit && (bus.PrAddr[1:0] == 2'd1);
  assign mode1     = (ctrl_mode == 2'b01);
  assign IRQ       = ctrl_im & irq_flag;

  always_comb begin
    bus.PrRD = 32'h0;
    if (hit) begin
      case (bus.PrAddr[1:0])
        2'd0:    bus.PrRD = {28'h0, ctrl_im, ctrl_mode, ctrl_en};
        2'd1:    bus.PrRD = preset;
        2'd2:    bus.PrRD = count;
        default: bus.PrRD = 32'h0;
      endcase
    end
  end

  // FSM acts on register values from before the edge; CPU writes are folded in below.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    irq_set   = 1'b0;
    irq_clr   = 1'b0;
    en_clr    = 1'b0;
    case (state)
      S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_nxt = S_IDLE;
        end else if (count <= 32'd1) begin
          count_nxt = 32'd0;
          irq_set   = 1'b1;
          state_nxt = S_INT;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      default: begin
`ifdef TIMER_MODE1_EN
        if (mode1) begin
          irq_clr   = 1'b1;
          state_nxt = ctrl_en ? S_LOAD : S_IDLE;
        end else begin
          en_clr    = 1'b1;
          state_nxt = S_IDLE;
        end
`else
        en_clr    = 1'b1;
        state_nxt = S_IDLE;
`endif
      end
    endcase
  end

`ifdef TIMER_MODE1_EN
  always_ff @(posedge clk) begin
    if (reset)        ctrl_mode <= 2'b00;
    else if (wr_ctrl) ctrl_mode <= bus.PrWD[2:1];
  end
`else
  assign ctrl_mode = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= 32'h0;
      preset   <= 32'h0;
      ctrl_en  <= 1'b0;
      ctrl_im  <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (wr_preset) preset <= bus.PrWD;
      // A CPU write to EN overrides the expiry-time EN clear.
      if (wr_ctrl) begin
        ctrl_en <= bus.PrWD[0];
        ctrl_im <= bus.PrWD[3];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      // Setting beats any clear so an expiry is never lost.
      if (irq_set)                            irq_flag <= 1'b1;
      else if (irq_clr || (wr_ctrl && !mode1)) irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: table of per-cycle bus vectors plus hand sequences.
module tb_timer_dev;

  localparam logic [29:0] A_CTRL = 30'h1FC0;
  localparam logic [29:0] A_PRE  = 30'h1FC1;
  localparam logic [29:0] A_CNT  = 30'h1FC2;
  localparam logic [29:0] A_RSV  = 30'h1FC3;
  localparam logic [29:0] A_OUT  = 30'h1FC4;
  localparam logic [29:0] A_ALT  = 30'h0FC1;
`ifdef TIMER_MODE1_EN
  localparam logic [31:0] CTRL_FULL = 32'hB;
`else
  localparam logic [31:0] CTRL_FULL = 32'h9;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   n_tests = 0;
  int   n_fail = 0;

  timer_dev_if bus ();

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic wr, logic [29:0] addr, logic [31:0] wd,
                             logic chk, logic [31:0] exp_rd, logic exp_irq);
    vec_t r;
    r.rst = rst; r.wr = wr; r.addr = addr; r.wd = wd;
    r.chk = chk; r.exp_rd = exp_rd; r.exp_irq = exp_irq;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [29:0] addr, input logic [31:0] wd);
    bus.PrWrite = wr;
    bus.PrAddr  = addr;
    bus.PrWD    = wd;
  endtask

  task automatic rd(input string name, input logic [29:0] addr, input logic [31:0] exp);
    drive(1'b0, addr, 32'h0);
    #1;
    check(name, bus.PrRD, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, A_CTRL, 32'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int rise, rise2;
    drive(1'b0, A_CTRL, 32'h0);

    // ---- rows are one cycle each; write lands on the edge that ends the row ----
    // reset state
    vecs.push_back(v(1, 0, A_CTRL, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, A_CTRL, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_PRE,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_RSV,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_OUT,  0, 1, 0, 0));
    // one-shot, PRESET=5, IM=1: COUNT 0,0,5,4,3,2,1,0 then IRQ after edge 7
    vecs.push_back(v(0, 1, A_PRE,  5, 1, 0, 0));
    vecs.push_back(v(0, 0, A_PRE,  0, 1, 5, 0));
    vecs.push_back(v(0, 1, A_CTRL, 9, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 5, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 4, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 3, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 2, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 1, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 1));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 8, 1));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 8, 1));
    vecs.push_back(v(0, 1, A_CTRL, 0, 1, 8, 1));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 0, 0));
    // out-of-window writes must not land
    vecs.push_back(v(0, 1, A_OUT, 32'hFFFF_FFFF, 1, 0, 0));
    vecs.push_back(v(0, 1, A_ALT, 32'hFFFF_FFFF, 1, 0, 0));
    vecs.push_back(v(0, 0, A_PRE,  0, 1, 5, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 0, 0));
    // IM=0, PRESET=2: expiry stays silent, later CTRL write clears the flag
    vecs.push_back(v(1, 0, A_CTRL, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, A_PRE,  2, 0, 0, 0));
    vecs.push_back(v(0, 1, A_CTRL, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 2, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 1, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, A_CTRL, 8, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 8, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 8, 0));
    // read-only and reserved words, CTRL upper bits
    vecs.push_back(v(1, 0, A_CTRL, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, A_CNT, 32'hFFFF_FFFF, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 1, A_RSV, 32'hFFFF_FFFF, 1, 0, 0));
    vecs.push_back(v(0, 0, A_RSV,  0, 1, 0, 0));
    vecs.push_back(v(0, 1, A_CTRL, 32'hFFFF_FFFB, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, CTRL_FULL, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    // PRESET=0: IRQ after edge 3; CTRL write on the set edge, then on the EN-clear edge
    vecs.push_back(v(1, 0, A_CTRL, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, A_CTRL, 9, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 0, A_CNT,  0, 1, 0, 0));
    vecs.push_back(v(0, 1, A_CTRL, 9, 1, 9, 0));
    vecs.push_back(v(0, 1, A_CTRL, 9, 1, 9, 1));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 9, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 9, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 9, 0));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 9, 1));
    vecs.push_back(v(0, 0, A_CTRL, 0, 1, 8, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
      if (!vecs[i].rst) begin
        if (vecs[i].chk) check($sformatf("row%0d PrRD", i), bus.PrRD, vecs[i].exp_rd);
        check($sformatf("row%0d IRQ", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    drive(1'b0, A_CTRL, 32'h0);

    // ---- reset two edges before expiry (PRESET=10, expiry would be edge 12) ----
    do_reset();
    drive(1'b1, A_PRE, 32'd10);
    tick();
    drive(1'b1, A_CTRL, 32'd9);
    tick();
    drive(1'b0, A_CTRL, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("rst_mid irq e%0d", k), {31'h0, irq}, 32'h0);
    end
    rd("rst_mid count e9", A_CNT, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid irq after", {31'h0, irq}, 32'h0);
    rd("rst_mid ctrl", A_CTRL, 32'h0);
    rd("rst_mid preset", A_PRE, 32'h0);
    rd("rst_mid count", A_CNT, 32'h0);
    rd("rst_mid rsv", A_RSV, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rst_mid quiet %0d", k), {31'h0, irq}, 32'h0);
    end

`ifdef TIMER_MODE1_EN
    // ---- auto-reload, PRESET=3: one-cycle pulses, then stop mid-count ----
    do_reset();
    drive(1'b1, A_PRE, 32'd3);
    tick();
    drive(1'b1, A_CTRL, 32'hB);
    tick();
    drive(1'b0, A_CNT, 32'h0);
    rise = -1;
    for (int c = 1; c <= 20 && rise < 0; c++) begin
      tick();
      if (irq) rise = c;
    end
    check("m1 first rise edge", rise, 32'd5);
    tick();
    check("m1 pulse width", {31'h0, irq}, 32'h0);
    rise2 = -1;
    for (int c = 2; c <= 12 && rise2 < 0; c++) begin
      tick();
      if (irq) rise2 = c;
    end
    check("m1 period", {31'h0, (rise2 == 4 || rise2 == 5)}, 32'h1);
    tick();
    check("m1 pulse2 width", {31'h0, irq}, 32'h0);
    tick();
    rd("m1 reload count", A_CNT, 32'd3);
    tick();
    drive(1'b1, A_CTRL, 32'hA);
    tick();
    drive(1'b0, A_CNT, 32'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      rd($sformatf("m1 frozen count %0d", k), A_CNT, 32'd1);
      check($sformatf("m1 no pulse %0d", k), {31'h0, irq}, 32'h0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
